// File: rtl/acc_seq_pkg.sv
// acc_seq_pkg: shared state encoding and elaboration helpers for the pass sequencer
package acc_seq_pkg;

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    localparam int DEF_PE_SIZE   = 14;
    localparam int DEF_ARRAY_LAT = 2;
    localparam int DRAIN_LEN     = DEF_ARRAY_LAT + DEF_PE_SIZE - 1;

    function automatic int num_pass(input int rows, input int pe);
        return (rows + pe - 1) / pe;
    endfunction

    // Bits needed to index v values, never less than 1
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int drain_len(input int lat, input int pe);
        return lat + pe - 1;
    endfunction

endpackage

// File: rtl/acc_pass_sequencer_skew.sv
// psum_en_skew: ARRAY_LAT-deep delay of the issue strobe followed by a per-column shift chain
module psum_en_skew #(
    parameter int PE_SIZE   = 14,
    parameter int ARRAY_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [PE_SIZE-1:0] psum_en_row
);

    localparam int N = ARRAY_LAT + PE_SIZE - 1;

    logic [N-1:0] pipe;

    // One shift register: the low ARRAY_LAT-1 taps are array latency, the rest is the column skew
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= N'({pipe, en});
    end

    assign psum_en_row = pipe[N-1:ARRAY_LAT-1];

endmodule

// File: rtl/acc_pass_sequencer.sv
// acc_pass_sequencer: row-tile pass sequencer for a weight-stationary MMU layer (optional ACC_SEQ_PERF_EN stall counter)
module acc_pass_sequencer
    import acc_seq_pkg::*;
#(
    parameter int PE_SIZE        = 14,
    parameter int WEIGHT_ROW_NUM = 294,
    parameter int WEIGHT_COL_NUM = 70,
    parameter int ARRAY_LAT      = 2,
    parameter int ADDR_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  wgt_ready_i,
    input  logic                  ifmap_ready_i,
    output logic                  wgt_rd_en_o,
    output logic [ADDR_WIDTH-1:0] wgt_addr_o,
    output logic                  wgt_zero_o,
    output logic                  ifmap_rd_en_o,
    output logic [ADDR_WIDTH-1:0] ifmap_addr_o,
    output logic [PE_SIZE-1:0]    psum_en_row_o,
    output logic                  first_pass_o,
    output logic                  last_pass_o,
    output logic [PE_SIZE-1:0]    ofmap_valid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [31:0]           stall_cnt_o
);

    localparam int NUM_PASS  = num_pass(WEIGHT_ROW_NUM, PE_SIZE);
    localparam int DRAIN_CYC = drain_len(ARRAY_LAT, PE_SIZE);
    localparam int PW = clog2(NUM_PASS);
    localparam int KW = clog2(PE_SIZE);
    localparam int CW = clog2(WEIGHT_COL_NUM);
    localparam int DW = clog2(DRAIN_CYC);
    localparam longint MAX_W = longint'(NUM_PASS) * PE_SIZE - 1;
    localparam longint MAX_I = longint'(NUM_PASS) * WEIGHT_COL_NUM - 1;

    if (ARRAY_LAT < 1 || (MAX_W >> ADDR_WIDTH) != 0 || (MAX_I >> ADDR_WIDTH) != 0) begin : g_bad_cfg
        $error("acc_pass_sequencer: ARRAY_LAT < 1 or address range exceeds ADDR_WIDTH");
    end

    state_t        state, state_nx;
    logic [PW-1:0] pass;
    logic [KW-1:0] k;
    logic [CW-1:0] col;
    logic [DW-1:0] dcnt;
    logic [31:0]   row;
    logic          valid_row, k_adv, k_end, col_end, d_end, pass_end;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Read strobes, addresses and next-state decode
    always_comb begin
        row           = 32'(pass) * 32'(PE_SIZE) + 32'(k);
        valid_row     = row < 32'(WEIGHT_ROW_NUM);
        wgt_zero_o    = state == LOAD_W && !valid_row;
        wgt_rd_en_o   = state == LOAD_W && valid_row && wgt_ready_i;
        ifmap_rd_en_o = state == STREAM && ifmap_ready_i;
        wgt_addr_o    = ADDR_WIDTH'(row);
        ifmap_addr_o  = ADDR_WIDTH'(32'(pass) * 32'(WEIGHT_COL_NUM) + 32'(col));
        busy_o        = state != IDLE;
        done_o        = state == DONE;
        k_adv         = wgt_rd_en_o || wgt_zero_o;
        k_end         = k == KW'(PE_SIZE - 1);
        col_end       = col == CW'(WEIGHT_COL_NUM - 1);
        d_end         = dcnt == DW'(DRAIN_CYC - 1);
        pass_end      = pass == PW'(NUM_PASS - 1);
        state_nx      = state;
        unique case (state)
            IDLE:    state_nx = start_i ? LOAD_W : IDLE;
            LOAD_W:  state_nx = (k_adv && k_end) ? STREAM : LOAD_W;
            STREAM:  state_nx = (ifmap_rd_en_o && col_end) ? DRAIN : STREAM;
            DRAIN:   state_nx = d_end ? (pass_end ? DONE : LOAD_W) : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    // Pass/row/column/drain counters and registered pass flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass         <= '0;
            k            <= '0;
            col          <= '0;
            dcnt         <= '0;
            first_pass_o <= 1'b0;
            last_pass_o  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start_i) begin
                    pass         <= '0;
                    k            <= '0;
                    col          <= '0;
                    first_pass_o <= 1'b1;
                    last_pass_o  <= NUM_PASS == 1;
                end
                LOAD_W: if (k_adv) k <= k_end ? '0 : k + 1'b1;
                STREAM: begin
                    dcnt <= '0;
                    if (ifmap_rd_en_o) col <= col_end ? '0 : col + 1'b1;
                end
                DRAIN: begin
                    dcnt <= dcnt + 1'b1;
                    if (d_end) begin
                        first_pass_o <= 1'b0;
                        last_pass_o  <= !pass_end && pass == PW'(NUM_PASS - 2);
                        pass         <= pass_end ? '0 : pass + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    psum_en_skew #(
        .PE_SIZE  (PE_SIZE),
        .ARRAY_LAT(ARRAY_LAT)
    ) u_skew (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (ifmap_rd_en_o),
        .psum_en_row(psum_en_row_o)
    );

    assign ofmap_valid_o = psum_en_row_o & {PE_SIZE{last_pass_o}};

`ifdef ACC_SEQ_PERF_EN
    logic stall;

    assign stall = (state == STREAM && !ifmap_ready_i) || (state == LOAD_W && valid_row && !wgt_ready_i);

    // Saturating stall counter, restarted when a layer is launched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         stall_cnt_o <= '0;
        else if (state == IDLE && start_i)  stall_cnt_o <= '0;
        else if (stall && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
    end
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_acc_pass_sequencer.sv
// tb_acc_pass_sequencer: scoreboard bench for the pass sequencer at PE_SIZE=4, 10 rows, 6 cols, latency 2
module tb_acc_pass_sequencer;

    localparam int P  = 4;
    localparam int R  = 10;
    localparam int C  = 6;
    localparam int L  = 2;
    localparam int AW = 16;
    localparam int NP = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          wgt_ready = 1'b1;
    logic          ifmap_ready = 1'b1;
    logic          wgt_rd_en, wgt_zero, ifmap_rd_en, first_pass, last_pass, busy, done;
    logic [AW-1:0] wgt_addr, ifmap_addr;
    logic [P-1:0]  psum_en, ofmap_valid;
    logic [31:0]   stall_cnt;

    typedef struct {int addr; bit zero; int pass;} wexp_t;
    typedef struct {int addr; int pass;} iexp_t;
    typedef struct {int cyc; int pass;} pexp_t;

    wexp_t wq[$];
    iexp_t iq[$];
    pexp_t pq[P][$];

    int nvec = 0, nerr = 0, cyc = 0;
    int active = 0, ndone = 0, nzero = 0, nov = 0;
    int pc[P];
    int s_act, s_done, s_zero, s_ov;
    int s_pc[P];
    int cur_pass = 0;
    bit pbusy = 0;
    wexp_t we;
    iexp_t ie;
    pexp_t pe;
    bit exp_on, exp_ov, exp_f, exp_l;

    always #5 clk = ~clk;

    acc_pass_sequencer #(
        .PE_SIZE       (P),
        .WEIGHT_ROW_NUM(R),
        .WEIGHT_COL_NUM(C),
        .ARRAY_LAT     (L),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .wgt_ready_i  (wgt_ready),
        .ifmap_ready_i(ifmap_ready),
        .wgt_rd_en_o  (wgt_rd_en),
        .wgt_addr_o   (wgt_addr),
        .wgt_zero_o   (wgt_zero),
        .ifmap_rd_en_o(ifmap_rd_en),
        .ifmap_addr_o (ifmap_addr),
        .psum_en_row_o(psum_en),
        .first_pass_o (first_pass),
        .last_pass_o  (last_pass),
        .ofmap_valid_o(ofmap_valid),
        .busy_o       (busy),
        .done_o       (done),
        .stall_cnt_o  (stall_cnt)
    );

    initial for (int j = 0; j < P; j++) pc[j] = 0;

    // Output monitor: pops expected reads as the DUT issues them, schedules and checks skewed psum pulses
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            wq.delete();
            iq.delete();
            for (int j = 0; j < P; j++) pq[j].delete();
            pbusy = 0;
        end else begin
            if (busy && !pbusy) cur_pass = 0;
            pbusy = busy;
            if (wgt_rd_en || wgt_zero) begin
                nvec++;
                if (wq.size() == 0) begin
                    nerr++;
                    $display("FAIL wgt_unexpected got addr=%0d zero=%0b rd=%0b", wgt_addr, wgt_zero, wgt_rd_en);
                end else begin
                    we = wq.pop_front();
                    cur_pass = we.pass;
                    if (wgt_addr !== AW'(we.addr) || wgt_zero !== we.zero || wgt_rd_en !== !we.zero) begin
                        nerr++;
                        $display("FAIL wgt_row got addr=%0d zero=%0b rd=%0b exp addr=%0d zero=%0b rd=%0b",
                                 wgt_addr, wgt_zero, wgt_rd_en, we.addr, we.zero, !we.zero);
                    end
                end
            end
            if (ifmap_rd_en) begin
                nvec++;
                if (iq.size() == 0) begin
                    nerr++;
                    $display("FAIL ifmap_unexpected got addr=%0d", ifmap_addr);
                end else begin
                    ie = iq.pop_front();
                    if (ifmap_addr !== AW'(ie.addr)) begin
                        nerr++;
                        $display("FAIL ifmap_addr got %0d exp %0d", ifmap_addr, ie.addr);
                    end
                    for (int j = 0; j < P; j++) pq[j].push_back('{cyc + L + j, ie.pass});
                end
            end
            for (int j = 0; j < P; j++) begin
                while (pq[j].size() > 0 && pq[j][0].cyc < cyc) begin
                    nvec++;
                    nerr++;
                    $display("FAIL psum_missing col=%0d exp cycle %0d got none", j, pq[j][0].cyc);
                    pe = pq[j].pop_front();
                end
                exp_on = pq[j].size() > 0 && pq[j][0].cyc == cyc;
                exp_ov = exp_on && pq[j][0].pass == NP - 1;
                if (exp_on) pe = pq[j].pop_front();
                nvec++;
                if (psum_en[j] !== exp_on || ofmap_valid[j] !== exp_ov) begin
                    nerr++;
                    $display("FAIL psum_col%0d cycle %0d got en=%0b ov=%0b exp en=%0b ov=%0b",
                             j, cyc, psum_en[j], ofmap_valid[j], exp_on, exp_ov);
                end
                if (psum_en[j]) pc[j]++;
                if (ofmap_valid[j]) nov++;
            end
            exp_f = busy && !done && cur_pass == 0;
            exp_l = busy && !done && cur_pass == NP - 1;
            nvec++;
            if (first_pass !== exp_f || last_pass !== exp_l) begin
                nerr++;
                $display("FAIL pass_flags cycle %0d got first=%0b last=%0b exp first=%0b last=%0b",
                         cyc, first_pass, last_pass, exp_f, exp_l);
            end
            if (busy && !done) active++;
            if (done) ndone++;
            if (wgt_zero) nzero++;
        end
    end

    task automatic push_layer();
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < P; k++) wq.push_back('{p * P + k, (p * P + k) >= R, p});
            for (int c = 0; c < C; c++) iq.push_back('{p * C + c, p});
        end
    endtask

    task automatic begin_layer();
        s_act  = active;
        s_done = ndone;
        s_zero = nzero;
        s_ov   = nov;
        for (int j = 0; j < P; j++) s_pc[j] = pc[j];
        push_layer();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic end_layer(output bit ok, output int act, output int dn, output int pmin, output int pmax,
                             output int ov, output int zr, output int left);
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
        repeat (2) @(negedge clk);
        act  = active - s_act;
        dn   = ndone - s_done;
        ov   = nov - s_ov;
        zr   = nzero - s_zero;
        pmin = 1 << 30;
        pmax = 0;
        left = wq.size() + iq.size();
        for (int j = 0; j < P; j++) begin
            pmin = (pc[j] - s_pc[j] < pmin) ? pc[j] - s_pc[j] : pmin;
            pmax = (pc[j] - s_pc[j] > pmax) ? pc[j] - s_pc[j] : pmax;
            left += pq[j].size();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        nvec++;
        if ({wgt_rd_en, wgt_zero, ifmap_rd_en, first_pass, last_pass, busy, done} !== 7'b0) begin
            nerr++;
            $display("FAIL reset_ctrl got %b exp 0000000",
                     {wgt_rd_en, wgt_zero, ifmap_rd_en, first_pass, last_pass, busy, done});
        end
        nvec++;
        if (wgt_addr !== '0 || ifmap_addr !== '0) begin
            nerr++;
            $display("FAIL reset_addr got w=%0d i=%0d exp 0 0", wgt_addr, ifmap_addr);
        end
        nvec++;
        if (psum_en !== '0 || ofmap_valid !== '0 || stall_cnt !== '0) begin
            nerr++;
            $display("FAIL reset_data got psum=%b ov=%b stall=%0d exp 0", psum_en, ofmap_valid, stall_cnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        bit ok;
        int act, dn, pmin, pmax, ov, zr, left;
        wgt_ready   = 1'b1;
        ifmap_ready = 1'b1;
        begin_layer();
        end_layer(ok, act, dn, pmin, pmax, ov, zr, left);
        nvec++;
        if (!ok) begin nerr++; $display("FAIL nominal_timeout got no done_o exp done within 400 cycles"); end
        nvec++;
        if (act !== 45) begin nerr++; $display("FAIL nominal_cycles got %0d exp 45", act); end
        nvec++;
        if (dn !== 1) begin nerr++; $display("FAIL nominal_done_width got %0d exp 1", dn); end
        nvec++;
        if (pmin !== 18 || pmax !== 18) begin
            nerr++;
            $display("FAIL nominal_pulses got min=%0d max=%0d exp 18", pmin, pmax);
        end
        nvec++;
        if (zr !== 2) begin nerr++; $display("FAIL nominal_zero_rows got %0d exp 2", zr); end
        nvec++;
        if (ov !== 4 * C) begin nerr++; $display("FAIL nominal_ofmap got %0d exp %0d", ov, 4 * C); end
        nvec++;
        if (left !== 0) begin nerr++; $display("FAIL nominal_leftover got %0d exp 0", left); end
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || stall_cnt !== 32'd0) begin
            nerr++;
            $display("FAIL nominal_idle got busy=%0b done=%0b stall=%0d exp 0 0 0", busy, done, stall_cnt);
        end
    endtask

    task automatic test_stall();
        bit ok, seen;
        int act, dn, pmin, pmax, ov, zr, left, exp_stall;
        begin_layer();
        wgt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 wgt_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (ifmap_rd_en && ifmap_addr == AW'(8)) seen = 1;
        end
        nvec++;
        if (!seen) begin nerr++; $display("FAIL stall_reach got no ifmap_addr 8 exp within 200 cycles"); end
        @(posedge clk);
        #1 ifmap_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            nvec++;
            if (ifmap_rd_en !== 1'b0 || ifmap_addr !== AW'(9)) begin
                nerr++;
                $display("FAIL stall_frozen got rd=%0b addr=%0d exp rd=0 addr=9", ifmap_rd_en, ifmap_addr);
            end
        end
        @(posedge clk);
        #1 ifmap_ready = 1'b1;
        end_layer(ok, act, dn, pmin, pmax, ov, zr, left);
        nvec++;
        if (!ok) begin nerr++; $display("FAIL stall_timeout got no done_o exp done within 400 cycles"); end
        nvec++;
        if (act !== 50) begin nerr++; $display("FAIL stall_cycles got %0d exp 50", act); end
        nvec++;
        if (pmin !== 18 || pmax !== 18) begin
            nerr++;
            $display("FAIL stall_pulses got min=%0d max=%0d exp 18", pmin, pmax);
        end
        nvec++;
        if (left !== 0) begin nerr++; $display("FAIL stall_leftover got %0d exp 0", left); end
`ifdef ACC_SEQ_PERF_EN
        exp_stall = 5;
`else
        exp_stall = 0;
`endif
        nvec++;
        if (stall_cnt !== 32'(exp_stall)) begin
            nerr++;
            $display("FAIL stall_count got %0d exp %0d", stall_cnt, exp_stall);
        end
    endtask

    task automatic test_abort();
        bit ok, seen;
        int act, dn, pmin, pmax, ov, zr, left, d0;
        begin_layer();
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (ifmap_rd_en) seen = 1;
        end
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 200 && seen; i++) begin
            @(negedge clk);
            if (ifmap_rd_en && ifmap_addr == AW'(C - 1)) seen = 0;
        end
        nvec++;
        if (seen) begin nerr++; $display("FAIL abort_reach got no last pass-0 column exp within 200 cycles"); end
        repeat (2) @(posedge clk);
        d0 = ndone;
        #1 rst_n = 1'b0;
        #1;
        nvec++;
        if ({wgt_rd_en, wgt_zero, ifmap_rd_en, first_pass, last_pass, busy, done} !== 7'b0 ||
            psum_en !== '0 || ofmap_valid !== '0 || stall_cnt !== '0 || wgt_addr !== '0 || ifmap_addr !== '0) begin
            nerr++;
            $display("FAIL abort_async got ctrl=%b psum=%b busy=%0b exp all 0",
                     {wgt_rd_en, wgt_zero, ifmap_rd_en, first_pass, last_pass, busy, done}, psum_en, busy);
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        nvec++;
        if (ndone - d0 !== 0) begin nerr++; $display("FAIL abort_no_done got %0d pulses exp 0", ndone - d0); end
        begin_layer();
        end_layer(ok, act, dn, pmin, pmax, ov, zr, left);
        nvec++;
        if (!ok || act !== 45 || dn !== 1) begin
            nerr++;
            $display("FAIL restart_layer got ok=%0b cycles=%0d done=%0d exp 1 45 1", ok, act, dn);
        end
        nvec++;
        if (pmin !== 18 || pmax !== 18 || left !== 0) begin
            nerr++;
            $display("FAIL restart_pulses got min=%0d max=%0d left=%0d exp 18 18 0", pmin, pmax, left);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish exp finish before 2ms");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
